// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file with busy scoreboard.
// No ports: holds the default widths, the hardwired-zero register address and
// the default register count used by the top level and its read ports.
package regfile_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 5;
    localparam int unsigned DEPTH      = 2 ** DEF_ADDR_W;
    localparam int unsigned ZERO_ADDR  = 0;

endpackage : regfile_pkg

// File: rtl/regfile_rd_port.sv
// One combinational read port of the register file.
// Looks up the stored register and busy bit, optionally forwards a same-cycle
// write (port 1 beats port 0), and forces the zero register to read as idle 0.
//   raddr_i        : read address
//   regs_i/busy_i  : flattened stored register contents and busy bits
//   we*_i/wa*_i/wd*_i : write ports, already masked for the zero register
//   iss_v_i/iss_a_i   : issue in this cycle (keeps the stored busy visible)
//   rdata_o/rbusy_o   : read data and busy flag
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic [ADDR_W-1:0]              raddr_i,
    input  logic [(2**ADDR_W)*DATA_W-1:0]  regs_i,
    input  logic [(2**ADDR_W)-1:0]         busy_i,
    input  logic                           we0_i,
    input  logic [ADDR_W-1:0]              wa0_i,
    input  logic [DATA_W-1:0]              wd0_i,
    input  logic                           we1_i,
    input  logic [ADDR_W-1:0]              wa1_i,
    input  logic [DATA_W-1:0]              wd1_i,
    input  logic                           iss_v_i,
    input  logic [ADDR_W-1:0]              iss_a_i,
    output logic [DATA_W-1:0]              rdata_o,
    output logic                           rbusy_o
);

    logic [DATA_W-1:0] stored_data;
    logic              stored_busy;
    logic              hit0;
    logic              hit1;
    logic              iss_hit;

    assign stored_data = regs_i[int'(raddr_i)*DATA_W +: DATA_W];
    assign stored_busy = busy_i[raddr_i];
    assign hit0        = we0_i && (wa0_i == raddr_i);
    assign hit1        = we1_i && (wa1_i == raddr_i);
    assign iss_hit     = iss_v_i && (iss_a_i == raddr_i);

    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        rdata_o = stored_data;
        rbusy_o = stored_busy;
        if (BYPASS && (hit0 || hit1)) begin
            rdata_o = hit1 ? wd1_i : wd0_i;
            // A write clears busy, but a same-cycle issue re-sets it, so the
            // stored value is the honest answer; an issue is never forwarded.
            rbusy_o = iss_hit ? stored_busy : 1'b0;
        end
        if (ZERO_REG && (raddr_i == ADDR_W'(ZERO_ADDR))) begin
            rdata_o = '0;
            rbusy_o = 1'b0;
        end
    end

endmodule : regfile_rd_port

// File: rtl/regfile_mp_sb.sv
// Multi-read-port register file with two prioritised write ports and a
// per-register busy scoreboard.
//   clk, rst_n       : clock, asynchronous active-low reset
//   raddr/rdata/rbusy: NUM_RD combinational read ports (slice i per port)
//   we0/wa0/wd0      : ALU writeback port
//   we1/wa1/wd1      : load writeback port, wins over port 0 on same address
//   iss_v/iss_a      : issue, marks the destination register busy
//   any_busy         : OR of all stored busy bits (not bypassed)
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned NUM_RD   = 2,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic [NUM_RD-1:0]        rbusy,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        wa0,
    input  logic [DATA_W-1:0]        wd0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        wa1,
    input  logic [DATA_W-1:0]        wd1,
    input  logic                     iss_v,
    input  logic [ADDR_W-1:0]        iss_a,
    output logic                     any_busy
);

    localparam int unsigned NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0]       regs_q [NREGS];
    logic [DATA_W-1:0]       regs_d [NREGS];
    logic [NREGS-1:0]        busy_q;
    logic [NREGS-1:0]        busy_d;
    logic [NREGS*DATA_W-1:0] regs_flat;
    logic                    we0_eff;
    logic                    we1_eff;
    logic                    iss_eff;

    // Traffic to the hardwired zero register is dropped at the source so the
    // storage, the scoreboard and the bypass paths never see it.
    assign we0_eff = we0   && !(ZERO_REG && (wa0   == ADDR_W'(ZERO_ADDR)));
    assign we1_eff = we1   && !(ZERO_REG && (wa1   == ADDR_W'(ZERO_ADDR)));
    assign iss_eff = iss_v && !(ZERO_REG && (iss_a == ADDR_W'(ZERO_ADDR)));

    // NOTE: blocking assignments here are evaluated in order, so a later
    // statement overrides an earlier one: port 1 beats port 0 on data, and the
    // issue set beats either write's busy clear.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (we0_eff) begin
            regs_d[wa0] = wd0;
            busy_d[wa0] = 1'b0;
        end
        if (we1_eff) begin
            regs_d[wa1] = wd1;
            busy_d[wa1] = 1'b0;
        end
        if (iss_eff) begin
            busy_d[iss_a] = 1'b1;
        end
    end

    // NOTE: the storage array is reset on purpose: the design must read 0
    // everywhere after reset, which costs a reset on every flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    assign any_busy = |busy_q;

    for (genvar g = 0; g < NREGS; g++) begin : g_flat
        assign regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        regfile_rd_port #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .ZERO_REG(ZERO_REG),
            .BYPASS  (BYPASS)
        ) u_rd_port (
            .raddr_i (raddr[p*ADDR_W +: ADDR_W]),
            .regs_i  (regs_flat),
            .busy_i  (busy_q),
            .we0_i   (we0_eff),
            .wa0_i   (wa0),
            .wd0_i   (wd0),
            .we1_i   (we1_eff),
            .wa1_i   (wa1),
            .wd1_i   (wd1),
            .iss_v_i (iss_v),
            .iss_a_i (iss_a),
            .rdata_o (rdata[p*DATA_W +: DATA_W]),
            .rbusy_o (rbusy[p])
        );
    end

endmodule : regfile_mp_sb

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench: one bypassing and one non-bypassing instance share the
// same stimulus; a register-array model tracks architectural state.
module tb_regfile_mp_sb;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int NREGS = 32;

    logic           clk;
    logic           rst_n;
    logic [NR*AW-1:0] raddr;
    logic           we0, we1, iss_v;
    logic [AW-1:0]  wa0, wa1, iss_a;
    logic [DW-1:0]  wd0, wd1;
    logic [NR*DW-1:0] rdata_b, rdata_n;
    logic [NR-1:0]  rbusy_b, rbusy_n;
    logic           any_busy_b, any_busy_n;

    int checks;
    int errors;

    logic [DW-1:0] mdl_reg  [NREGS];
    bit            mdl_busy [NREGS];

    regfile_mp_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_byp (
        .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .iss_v(iss_v), .iss_a(iss_a), .any_busy(any_busy_b)
    );

    regfile_mp_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1'b1), .BYPASS(1'b0)) u_nobyp (
        .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata_n), .rbusy(rbusy_n),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .iss_v(iss_v), .iss_a(iss_a), .any_busy(any_busy_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- observation helpers (no checking) ----------------
    function automatic logic [DW-1:0] rd(input bit byp, input int p);
        return byp ? rdata_b[p*DW +: DW] : rdata_n[p*DW +: DW];
    endfunction

    function automatic logic rb(input bit byp, input int p);
        return byp ? rbusy_b[p] : rbusy_n[p];
    endfunction

    function automatic logic ab(input bit byp);
        return byp ? any_busy_b : any_busy_n;
    endfunction

    function automatic int ra(input int p);
        return int'(raddr[p*AW +: AW]);
    endfunction

    // ---------------- reference model ----------------
    // Expected read data: zero register reads 0; with bypass, the winning
    // same-cycle write (port 1 first) is visible; otherwise stored state.
    function automatic logic [DW-1:0] exp_data(input int a, input bit byp);
        if (a == 0) return '0;
        if (byp && we1 && int'(wa1) == a) return wd1;
        if (byp && we0 && int'(wa0) == a) return wd0;
        return mdl_reg[a];
    endfunction

    function automatic logic exp_busy(input int a, input bit byp);
        bit wr_hit;
        if (a == 0) return 1'b0;
        wr_hit = (we1 && int'(wa1) == a) || (we0 && int'(wa0) == a);
        if (byp && wr_hit && !(iss_v && int'(iss_a) == a)) return 1'b0;
        return mdl_busy[a];
    endfunction

    function automatic logic exp_any();
        logic r;
        r = 1'b0;
        for (int i = 0; i < NREGS; i++) r = r | mdl_busy[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) begin
            mdl_reg[i]  = '0;
            mdl_busy[i] = 1'b0;
        end
    endtask

    task automatic model_update();
        if (we0 && wa0 != 0) begin mdl_reg[wa0] = wd0; mdl_busy[wa0] = 1'b0; end
        if (we1 && wa1 != 0) begin mdl_reg[wa1] = wd1; mdl_busy[wa1] = 1'b0; end
        if (iss_v && iss_a != 0) mdl_busy[iss_a] = 1'b1;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        we0 = 1'b0; wa0 = '0; wd0 = '0;
        we1 = 1'b0; wa1 = '0; wd1 = '0;
        iss_v = 1'b0; iss_a = '0;
    endtask

    task automatic set_raddr(input int a0, input int a1);
        raddr = {AW'(a1), AW'(a0)};
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    function automatic int rand_addr();
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, NREGS - 1));
        return int'($urandom_range(0, 5));
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        set_raddr(0, 0);
        model_reset();
        #2;
        for (int a = 0; a < NREGS; a++) begin
            set_raddr(a, NREGS - 1 - a);
            #1;
            for (int d = 0; d < 2; d++) begin
                for (int p = 0; p < NR; p++) begin
                    checks++;
                    if (rd(d[0], p) !== '0) begin
                        errors++;
                        $display("FAIL reset_rdata dut%0d port%0d addr%0d: got %h expected 0", d, p, ra(p), rd(d[0], p));
                    end
                    checks++;
                    if (rb(d[0], p) !== 1'b0) begin
                        errors++;
                        $display("FAIL reset_rbusy dut%0d port%0d addr%0d: got %b expected 0", d, p, ra(p), rb(d[0], p));
                    end
                end
                checks++;
                if (ab(d[0]) !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_any_busy dut%0d: got %b expected 0", d, ab(d[0]));
                end
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_scoreboard();
        idle();
        iss_v = 1'b1; iss_a = 5'd3;
        set_raddr(3, 3);
        #1;
        checks++;
        if (rb(1, 0) !== 1'b0) begin
            errors++;
            $display("FAIL sb_issue_not_forwarded: got %b expected 0", rb(1, 0));
        end
        tick();
        idle();
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (rb(d[0], 1) !== 1'b1 || ab(d[0]) !== 1'b1) begin
                errors++;
                $display("FAIL sb_busy_set dut%0d: rbusy %b any_busy %b expected 1 1", d, rb(d[0], 1), ab(d[0]));
            end
        end
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h0000_0042;
        #1;
        checks++;
        if (rd(1, 0) !== 32'h0000_0042 || rb(1, 0) !== 1'b0) begin
            errors++;
            $display("FAIL sb_write_bypass: rdata %h rbusy %b expected 00000042 0", rd(1, 0), rb(1, 0));
        end
        checks++;
        if (rd(0, 0) !== 32'h0 || rb(0, 0) !== 1'b1) begin
            errors++;
            $display("FAIL sb_write_nobypass: rdata %h rbusy %b expected 00000000 1", rd(0, 0), rb(0, 0));
        end
        tick();
        idle();
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (rd(d[0], 0) !== 32'h0000_0042 || rb(d[0], 0) !== 1'b0 || ab(d[0]) !== 1'b0) begin
                errors++;
                $display("FAIL sb_cleared dut%0d: rdata %h rbusy %b any_busy %b expected 00000042 0 0",
                         d, rd(d[0], 0), rb(d[0], 0), ab(d[0]));
            end
        end
    endtask

    task automatic test_collision();
        idle();
        we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h1111_1111;
        we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h2222_2222;
        set_raddr(9, 9);
        #1;
        checks++;
        if (rd(1, 0) !== 32'h2222_2222 || rb(1, 1) !== 1'b0) begin
            errors++;
            $display("FAIL collision_bypass: rdata %h rbusy %b expected 22222222 0", rd(1, 0), rb(1, 1));
        end
        tick();
        idle();
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (rd(d[0], 1) !== 32'h2222_2222) begin
                errors++;
                $display("FAIL collision_stored dut%0d: got %h expected 22222222", d, rd(d[0], 1));
            end
        end
    endtask

    task automatic test_zero();
        idle();
        we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFF_FFFF;
        we1 = 1'b1; wa1 = 5'd0; wd1 = 32'hFFFF_FFFF;
        iss_v = 1'b1; iss_a = 5'd0;
        set_raddr(0, 0);
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (rd(d[0], 0) !== '0 || rb(d[0], 1) !== 1'b0) begin
                errors++;
                $display("FAIL zero_same_cycle dut%0d: rdata %h rbusy %b expected 0 0", d, rd(d[0], 0), rb(d[0], 1));
            end
        end
        tick();
        idle();
        for (int c = 0; c < 3; c++) begin
            #1;
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (rd(d[0], 0) !== '0 || rb(d[0], 0) !== 1'b0 || ab(d[0]) !== 1'b0) begin
                    errors++;
                    $display("FAIL zero_after dut%0d cyc%0d: rdata %h rbusy %b any_busy %b expected 0 0 0",
                             d, c, rd(d[0], 0), rb(d[0], 0), ab(d[0]));
                end
            end
            tick();
        end
    endtask

    task automatic test_set_clear();
        idle();
        iss_v = 1'b1; iss_a = 5'd4;
        tick();
        idle();
        iss_v = 1'b1; iss_a = 5'd4;
        we1 = 1'b1; wa1 = 5'd4; wd1 = 32'hA5A5_A5A5;
        set_raddr(4, 4);
        #1;
        checks++;
        if (rd(1, 0) !== 32'hA5A5_A5A5 || rb(1, 0) !== 1'b1) begin
            errors++;
            $display("FAIL setclr_bypass: rdata %h rbusy %b expected a5a5a5a5 1", rd(1, 0), rb(1, 0));
        end
        tick();
        idle();
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (rd(d[0], 1) !== 32'hA5A5_A5A5 || rb(d[0], 1) !== 1'b1 || ab(d[0]) !== 1'b1) begin
                errors++;
                $display("FAIL setclr_after dut%0d: rdata %h rbusy %b any_busy %b expected a5a5a5a5 1 1",
                         d, rd(d[0], 1), rb(d[0], 1), ab(d[0]));
            end
        end
    endtask

    task automatic test_bypass();
        idle();
        we0 = 1'b1; wa0 = 5'd12; wd0 = 32'h1234_5678;
        set_raddr(12, 12);
        #1;
        for (int p = 0; p < NR; p++) begin
            checks++;
            if (rd(1, p) !== 32'h1234_5678) begin
                errors++;
                $display("FAIL bypass_on port%0d: got %h expected 12345678", p, rd(1, p));
            end
            checks++;
            if (rd(0, p) !== 32'h0) begin
                errors++;
                $display("FAIL bypass_off_old port%0d: got %h expected 00000000", p, rd(0, p));
            end
        end
        tick();
        idle();
        #1;
        for (int p = 0; p < NR; p++) begin
            checks++;
            if (rd(0, p) !== 32'h1234_5678) begin
                errors++;
                $display("FAIL bypass_off_new port%0d: got %h expected 12345678", p, rd(0, p));
            end
        end
    endtask

    task automatic test_random(input int n);
        for (int c = 0; c < n; c++) begin
            we0 = 1'($urandom_range(0, 1)); wa0 = AW'(rand_addr()); wd0 = $urandom;
            we1 = 1'($urandom_range(0, 1)); wa1 = AW'(rand_addr()); wd1 = $urandom;
            iss_v = 1'($urandom_range(0, 1)); iss_a = AW'(rand_addr());
            set_raddr(rand_addr(), rand_addr());
            #1;
            for (int d = 0; d < 2; d++) begin
                for (int p = 0; p < NR; p++) begin
                    checks++;
                    if (rd(d[0], p) !== exp_data(ra(p), d[0])) begin
                        errors++;
                        $display("FAIL rand_rdata cyc%0d dut%0d port%0d addr%0d: got %h expected %h",
                                 c, d, p, ra(p), rd(d[0], p), exp_data(ra(p), d[0]));
                    end
                    checks++;
                    if (rb(d[0], p) !== exp_busy(ra(p), d[0])) begin
                        errors++;
                        $display("FAIL rand_rbusy cyc%0d dut%0d port%0d addr%0d: got %b expected %b",
                                 c, d, p, ra(p), rb(d[0], p), exp_busy(ra(p), d[0]));
                    end
                end
                checks++;
                if (ab(d[0]) !== exp_any()) begin
                    errors++;
                    $display("FAIL rand_any_busy cyc%0d dut%0d: got %b expected %b", c, d, ab(d[0]), exp_any());
                end
            end
            tick();
        end
        idle();
    endtask

    task automatic test_reset_mid();
        idle();
        we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEAD_BEEF;
        iss_v = 1'b1; iss_a = 5'd7;
        tick();
        idle();
        set_raddr(5, 7);
        #1;
        checks++;
        if (rd(0, 0) !== 32'hDEAD_BEEF || rb(0, 1) !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre: rdata %h rbusy %b expected deadbeef 1", rd(0, 0), rb(0, 1));
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (rd(d[0], 0) !== '0 || rb(d[0], 1) !== 1'b0 || ab(d[0]) !== 1'b0) begin
                errors++;
                $display("FAIL rstmid dut%0d: rdata %h rbusy %b any_busy %b expected 0 0 0",
                         d, rd(d[0], 0), rb(d[0], 1), ab(d[0]));
            end
        end
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_scoreboard();
        test_collision();
        test_zero();
        test_set_clear();
        test_bypass();
        test_random(400);
        test_reset_mid();
        test_random(100);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_regfile_mp_sb

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised successor to the single-write, two-read CPU register file.
- Adds:
  - a configurable number of read ports
  - two write ports (ALU writeback and load writeback) with fixed priority
  - optional same-cycle write-to-read bypass
  - a per-register busy scoreboard for hazard detection in the pipelined core
- Sits between decode (read and issue) and writeback.
- Resettable, unlike the previous generation.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth is 2**ADDR_W registers
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 is hardwired to zero, never busy, writes ignored
- BYPASS, 1, 1 = same-cycle write data and busy-clear are forwarded to the read ports

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- raddr  in  NUM_RD*ADDR_W  read addresses; port i occupies bits [i*ADDR_W +: ADDR_W]
- rdata  out  NUM_RD*DATA_W  read data, one DATA_W slice per port
- rbusy  out  NUM_RD  busy flag of the addressed register, one bit per port
- we0  in  1  write enable, port 0 (ALU)
- wa0  in  ADDR_W  write address, port 0
- wd0  in  DATA_W  write data, port 0
- we1  in  1  write enable, port 1 (load); has priority over port 0
- wa1  in  ADDR_W  write address, port 1
- wd1  in  DATA_W  write data, port 1
- iss_v  in  1  issue valid; marks iss_a busy
- iss_a  in  ADDR_W  destination register of the issued instruction
- any_busy  out  1  OR of all busy bits

Behaviour:
- Reset (rst_n low, asynchronous):
  - all registers clear to 0 and all busy bits clear to 0
  - rdata then reads 0 for every address; rbusy = 0; any_busy = 0
  - after release, first update on the next rising clk edge
- Writes (rising clk edge):
  - weX=1 stores wdX into reg[waX] and clears busy[waX]
  - we0 and we1 both set with wa0==wa1: wd1 is stored (port 1 wins); busy is cleared once
  - different addresses: both are written in the same cycle
- Issue (rising clk edge): iss_v=1 sets busy[iss_a].
  - Set/clear collision on the same address: the issue set wins, so busy stays 1 (a newer producer is in flight).
  - The data write still happens in that cycle.
- Zero register (ZERO_REG=1), address 0:
  - writes and issues to address 0 have no effect
  - reads of address 0 always return rdata=0 and rbusy=0, regardless of bypass
- Reads are combinational, zero-latency.
  - BYPASS=0: rdata = stored reg[raddr]; rbusy = stored busy[raddr]. A same-cycle write becomes visible next cycle.
  - BYPASS=1, raddr matches an active write this cycle: rdata = the winning write data (port-1 priority applies); rbusy = 0, unless iss_v && iss_a==raddr, in which case the stored busy value is presented.
  - A same-cycle issue never forward-sets rbusy; it becomes visible next cycle.
- any_busy is registered-state only and is not bypassed.
- Write to a non-busy register is legal: data is updated, busy stays 0.
- Issue to an already-busy register is legal: busy stays 1 and there is no error indication.
- No X propagation: unused raddr ports read the addressed register normally.

Decomposition:
- Shared package regfile_pkg:
  - default DATA_W/ADDR_W constants
  - ZERO_ADDR constant
  - localparam DEPTH = 2**ADDR_W
- One natural sub-module, regfile_rd_port:
  - handles one read port: stored lookup, bypass mux with write-priority, zero-register override
  - instantiated NUM_RD times in a generate loop
- Storage, write logic and scoreboard stay in the top.

Test Plan:
- Reset mid-operation:
  - write 0xDEADBEEF to r5 and issue r7, then pulse rst_n low between edges
  - required: immediately rdata(r5)=0, rbusy(r7)=0, any_busy=0
- Dual-write collision:
  - we0=we1=1, wa0=wa1=9, wd0=0x11111111, wd1=0x22222222
  - required next cycle: r9 reads 0x22222222
  - required with BYPASS=1, same cycle: rdata=0x22222222, rbusy=0
- Zero register:
  - write 0xFFFFFFFF to r0 and issue r0
  - required: rdata(r0)=0 and rbusy(r0)=0 on all following cycles; any_busy=0
- Scoreboard lifecycle:
  - issue r3
  - required next cycle: rbusy=1, any_busy=1
  - then we0 to r3 with 0x00000042
  - required next cycle: rbusy=0, any_busy=0, rdata=0x00000042
- Set/clear collision:
  - r4 busy; in the same cycle iss_v to r4 and we1 to r4 with 0xA5A5A5A5
  - required next cycle: rbusy(r4)=1, rdata=0xA5A5A5A5
- BYPASS=0 vs BYPASS=1:
  - write 0x12345678 to r12 while reading r12 on both ports
  - BYPASS=1, same cycle: both ports return 0x12345678
  - BYPASS=0: old value in the write cycle, new value the next cycle
